// File: rtl/ctrl_convseq_pkg.sv
// Shared types and constants for the sample-rate converter sequencer:
// state encoding, strobe bit positions and the strobe decode.
package ctrl_convseq_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_HINIT, S_INC, S_HEAD, S_LOAD, S_RUN, S_DONE
    } state_t;

    localparam int NUM_VEC_DEF  = 32;
    localparam int MAX_TAPS_DEF = 1023;

    localparam int STB_W          = 9;
    localparam int B_ADDR_CLR     = 0;
    localparam int B_HEADER_INIT  = 1;
    localparam int B_RINGBUF_INIT = 2;
    localparam int B_COEFF_LOAD   = 3;
    localparam int B_CNT          = 4;
    localparam int B_HEAD_READ    = 5;
    localparam int B_HEAD_INCR    = 6;
    localparam int B_MAC_CLR      = 7;
    localparam int B_CONV_DONE    = 8;

    // Strobe pattern that is active while the sequencer sits in state s.
    function automatic logic [STB_W-1:0] decode_strobes(input state_t s);
        logic [STB_W-1:0] b;
        b = '0;
        case (s)
            S_CLR:   begin b[B_ADDR_CLR] = 1'b1; b[B_RINGBUF_INIT] = 1'b1; end
            S_HINIT: b[B_HEADER_INIT] = 1'b1;
            S_INC:   b[B_HEAD_INCR] = 1'b1;
            S_HEAD:  b[B_HEAD_READ] = 1'b1;
            S_LOAD:  begin
                b[B_COEFF_LOAD]   = 1'b1;
                b[B_RINGBUF_INIT] = 1'b1;
                b[B_MAC_CLR]      = 1'b1;
            end
            S_RUN:   b[B_CNT] = 1'b1;
            S_DONE:  b[B_CONV_DONE] = 1'b1;
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ctrl_convseq_if.sv
// Control bus between the rate controller, the sequencer and the
// address driver / MAC. The slave modport is the sequencer's view.
interface ctrl_convseq_if #(
    parameter int INDEX_WIDTH = 5
);
    logic                   init_req;
    logic                   smp_push;
    logic [INDEX_WIDTH-1:0] smp_vec;
    logic                   conv_start;
    logic [INDEX_WIDTH-1:0] conv_phase;
    logic                   conv_pass;

    logic                   ready;
    logic                   init_done;
    logic                   conv_done;
    logic                   addr_clr;
    logic                   header_init;
    logic                   ringbuf_init;
    logic                   coeff_load;
    logic                   cnt;
    logic                   head_read;
    logic                   head_incr;
    logic [INDEX_WIDTH-1:0] vector_id;
    logic                   mac_clr;
    logic                   mac_en;
    logic                   mac_last;
    logic                   err_wdog;
    logic                   err_ovf;

    modport slave (
        input  init_req, smp_push, smp_vec, conv_start, conv_phase, conv_pass,
        output ready, init_done, conv_done, addr_clr, header_init, ringbuf_init,
               coeff_load, cnt, head_read, head_incr, vector_id, mac_clr,
               mac_en, mac_last, err_wdog, err_ovf
    );

    modport master (
        output init_req, smp_push, smp_vec, conv_start, conv_phase, conv_pass,
        input  ready, init_done, conv_done, addr_clr, header_init, ringbuf_init,
               coeff_load, cnt, head_read, head_incr, vector_id, mac_clr,
               mac_en, mac_last, err_wdog, err_ovf
    );
endinterface

// File: rtl/ctrl_convseq_wdog.sv
// Tap counter for one convolution; flags the cycle on which the
// MAX_TAPS-th count enable arrives.
module ctrl_convseq_wdog #(
    parameter int TAP_WIDTH = 10,
    parameter int MAX_TAPS  = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [TAP_WIDTH-1:0] tap;

    always_ff @(posedge clk) begin
        if (rst || clr)
            tap <= '0;
        else if (en)
            tap <= tap + TAP_WIDTH'(1);
    end

    assign expired = en && (tap == TAP_WIDTH'(MAX_TAPS - 1));
endmodule

// File: rtl/ctrl_convseq.sv
// Sequencer for header init, ring-buffer head advance and polyphase
// convolution; strobes are registered copies of the state decode.
module ctrl_convseq
    import ctrl_convseq_pkg::*;
#(
    parameter int INDEX_WIDTH = 5,
    parameter int NUM_VEC     = NUM_VEC_DEF,
    parameter int TAP_WIDTH   = 10,
    parameter int MAX_TAPS    = MAX_TAPS_DEF
) (
    input  logic clk,
    input  logic rst,
    ctrl_convseq_if.slave bus
);
    state_t                 state, state_n;
    logic [STB_W-1:0]       stb;
    logic                   pend;
    logic [INDEX_WIDTH-1:0] pend_vec;
    logic [INDEX_WIDTH-1:0] vid;
    logic                   init_done_q;
    logic                   err_wdog_q;
    logic                   err_ovf_q;
    logic                   expired;
    logic                   hinit_last;
    logic                   pend_clr;
    logic                   run;
    logic                   load;

    // During HINIT vector_id doubles as the entry counter.
    assign hinit_last = (vid == INDEX_WIDTH'(NUM_VEC - 1));
    assign pend_clr   = (state == S_INC);
    assign run        = (state == S_RUN);
    assign load       = (state == S_LOAD);

    ctrl_convseq_wdog #(.TAP_WIDTH(TAP_WIDTH), .MAX_TAPS(MAX_TAPS)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (load),
        .en      (run),
        .expired (expired)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (bus.init_req)        state_n = S_CLR;
                else if (pend)           state_n = S_INC;
                else if (bus.conv_start) state_n = S_HEAD;
            end
            S_CLR:   state_n = S_HINIT;
            S_HINIT: if (hinit_last) state_n = S_IDLE;
            S_INC:   state_n = S_IDLE;
            S_HEAD:  state_n = S_LOAD;
            S_LOAD:  state_n = S_RUN;
            S_RUN:   if (bus.conv_pass || expired) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            stb         <= '0;
            pend        <= 1'b0;
            pend_vec    <= '0;
            vid         <= '0;
            init_done_q <= 1'b0;
            err_wdog_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state       <= state_n;
            stb         <= decode_strobes(state_n);
            init_done_q <= (state == S_HINIT) && hinit_last;

            case (state_n)
                S_HINIT: vid <= (state == S_HINIT) ? vid + INDEX_WIDTH'(1) : '0;
                S_INC:   vid <= pend_vec;
                S_HEAD:  vid <= bus.conv_phase;
                default: vid <= vid;
            endcase

            // A push landing on the INC cycle re-arms pend cleanly.
            if (bus.smp_push) begin
                pend     <= 1'b1;
                pend_vec <= bus.smp_vec;
                if (pend && !pend_clr) err_ovf_q <= 1'b1;
            end else if (pend_clr) begin
                pend <= 1'b0;
            end

            if (run && !bus.conv_pass && expired) err_wdog_q <= 1'b1;
        end
    end

    assign bus.ready        = (state == S_IDLE) && !pend;
    assign bus.init_done    = init_done_q;
    assign bus.conv_done    = stb[B_CONV_DONE];
    assign bus.addr_clr     = stb[B_ADDR_CLR];
    assign bus.header_init  = stb[B_HEADER_INIT];
    assign bus.ringbuf_init = stb[B_RINGBUF_INIT];
    assign bus.coeff_load   = stb[B_COEFF_LOAD];
    assign bus.cnt          = stb[B_CNT];
    assign bus.head_read    = stb[B_HEAD_READ];
    assign bus.head_incr    = stb[B_HEAD_INCR];
    assign bus.vector_id    = vid;
    assign bus.mac_clr      = stb[B_MAC_CLR];
    assign bus.mac_en       = stb[B_CNT];
    assign bus.mac_last     = run && bus.conv_pass;
    assign bus.err_wdog     = err_wdog_q;
    assign bus.err_ovf      = err_ovf_q;
endmodule
